// File: rtl/fire_ctrl_pkg.sv
// Shared types and size helpers for the fire expand convolution sequencer.
package fire_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} seq_state_t;

    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int taps_f(input int k, input int chin);
        return k * k * chin;
    endfunction

    function automatic int npix_f(input int w, input int h);
        return w * h;
    endfunction

    localparam int W_IN_DEF  = 64;
    localparam int H_IN_DEF  = 64;
    localparam int CHIN_DEF  = 16;
    localparam int K_DEF     = 3;
    localparam int TAPS      = taps_f(K_DEF, CHIN_DEF);
    localparam int NPIX      = npix_f(W_IN_DEF, H_IN_DEF);
    localparam int IFM_AW    = addr_w(NPIX * CHIN_DEF);
    localparam int W_AW      = addr_w(TAPS);
    localparam int PIX_AW    = addr_w(NPIX);

endpackage

// File: rtl/fire_expand_sequencer_if.sv
// Control/address bundle between the sequencer (master) and its host + MAC array (slave).
interface fire_expand_sequencer_if #(
    parameter int IFM_AW = 16,
    parameter int W_AW   = 8,
    parameter int PIX_AW = 12
);
    logic              start;
    logic              hold;
    logic [IFM_AW-1:0] ifm_addr;
    logic              pad_zero;
    logic [W_AW-1:0]   w_addr;
    logic              mac_en;
    logic              mac_clr;
    logic              ofm_sample;
    logic [PIX_AW-1:0] ofm_pix;
    logic              busy;
    logic              layer_end;

    modport master (
        input  start, hold,
        output ifm_addr, pad_zero, w_addr, mac_en, mac_clr, ofm_sample, ofm_pix, busy, layer_end
    );

    modport slave (
        output start, hold,
        input  ifm_addr, pad_zero, w_addr, mac_en, mac_clr, ofm_sample, ofm_pix, busy, layer_end
    );
endinterface

// File: rtl/fire_tap_counter.sv
// Cascaded ch/kx/ky/ox/oy tap walker with padding detection and ifm/weight/pixel address generation.
module fire_tap_counter
    import fire_ctrl_pkg::*;
#(
    parameter int W_IN       = 64,
    parameter int H_IN       = 64,
    parameter int CHIN       = 16,
    parameter int KERNEL_DIM = 3,
    parameter int PAD        = 1,
    parameter int IA         = addr_w(W_IN * H_IN * CHIN),
    parameter int TW         = addr_w(taps_f(KERNEL_DIM, CHIN)),
    parameter int PW         = addr_w(W_IN * H_IN)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear_i,
    input  logic          advance_i,
    output logic [IA-1:0] ifm_addr_o,
    output logic [TW-1:0] w_addr_o,
    output logic [PW-1:0] pix_o,
    output logic          pad_zero_o,
    output logic          first_o,
    output logic          last_o,
    output logic          layer_last_o
);
    localparam int CHW = addr_w(CHIN);
    localparam int KW  = addr_w(KERNEL_DIM);
    localparam int XW  = addr_w(W_IN);
    localparam int YW  = addr_w(H_IN);
    localparam int CW  = addr_w((W_IN > H_IN) ? W_IN : H_IN) + 2;

    localparam logic [CHW-1:0] CH_MAX = CHW'(CHIN - 1);
    localparam logic [KW-1:0]  K_MAX  = KW'(KERNEL_DIM - 1);
    localparam logic [XW-1:0]  X_MAX  = XW'(W_IN - 1);
    localparam logic [YW-1:0]  Y_MAX  = YW'(H_IN - 1);
    localparam logic signed [CW-1:0] W_LIM = CW'(W_IN);
    localparam logic signed [CW-1:0] H_LIM = CW'(H_IN);

    logic [CHW-1:0] ch_q, ch_d;
    logic [KW-1:0]  kx_q, kx_d, ky_q, ky_d;
    logic [XW-1:0]  ox_q, ox_d;
    logic [YW-1:0]  oy_q, oy_d;
    logic signed [CW-1:0] iy, ix;
    logic [IA-1:0]  lin_addr;

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            ch_q <= '0;
            kx_q <= '0;
            ky_q <= '0;
            ox_q <= '0;
            oy_q <= '0;
        end else begin
            ch_q <= ch_d;
            kx_q <= kx_d;
            ky_q <= ky_d;
            ox_q <= ox_d;
            oy_q <= oy_d;
        end
    end

    // Innermost-first cascade; each counter wraps only when everything inside it wraps.
    always_comb begin
        ch_d = ch_q;
        kx_d = kx_q;
        ky_d = ky_q;
        ox_d = ox_q;
        oy_d = oy_q;
        if (advance_i) begin
            if (ch_q != CH_MAX) ch_d = ch_q + 1'b1;
            else begin
                ch_d = '0;
                if (kx_q != K_MAX) kx_d = kx_q + 1'b1;
                else begin
                    kx_d = '0;
                    if (ky_q != K_MAX) ky_d = ky_q + 1'b1;
                    else begin
                        ky_d = '0;
                        if (ox_q != X_MAX) ox_d = ox_q + 1'b1;
                        else begin
                            ox_d = '0;
                            oy_d = (oy_q != Y_MAX) ? oy_q + 1'b1 : '0;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        iy         = CW'(oy_q) + CW'(ky_q) - CW'(PAD);
        ix         = CW'(ox_q) + CW'(kx_q) - CW'(PAD);
        pad_zero_o = iy[CW-1] || ix[CW-1] || (iy >= H_LIM) || (ix >= W_LIM);
        lin_addr   = (IA'($unsigned(iy)) * IA'(W_IN) + IA'($unsigned(ix))) * IA'(CHIN) + IA'(ch_q);
        ifm_addr_o = pad_zero_o ? '0 : lin_addr;
        w_addr_o   = (TW'(ky_q) * TW'(KERNEL_DIM) + TW'(kx_q)) * TW'(CHIN) + TW'(ch_q);
        pix_o      = PW'(oy_q) * PW'(W_IN) + PW'(ox_q);
    end

    assign first_o      = (ch_q == '0) && (kx_q == '0) && (ky_q == '0);
    assign last_o       = (ch_q == CH_MAX) && (kx_q == K_MAX) && (ky_q == K_MAX);
    assign layer_last_o = last_o && (ox_q == X_MAX) && (oy_q == Y_MAX);

endmodule

// File: rtl/fire_expand_sequencer.sv
// Layer sequencer: FSM, tap issue, ROM-latency alignment of MAC strobes, and MAC-latency sample timing.
module fire_expand_sequencer
    import fire_ctrl_pkg::*;
#(
    parameter int W_IN       = 64,
    parameter int H_IN       = 64,
    parameter int CHIN       = 16,
    parameter int KERNEL_DIM = 3,
    parameter int PAD        = 1,
    parameter int ROM_LAT    = 1,
    parameter int MAC_LAT    = 2
) (
    input  logic clk,
    input  logic rst,
    fire_expand_sequencer_if.master bus
);
    localparam int NPIX_L    = npix_f(W_IN, H_IN);
    localparam int TAPS_L    = taps_f(KERNEL_DIM, CHIN);
    localparam int IA        = addr_w(NPIX_L * CHIN);
    localparam int TW        = addr_w(TAPS_L);
    localparam int PW        = addr_w(NPIX_L);
    localparam int DRAIN_LEN = ROM_LAT + MAC_LAT;
    localparam int DW        = addr_w(DRAIN_LEN + 1);

    seq_state_t     state_q, state_d;
    logic [DW-1:0]  drain_q;
    logic           run, issue, clear;
    logic           busy_d, layer_end_d;
    logic [IA-1:0]  ifm_addr;
    logic [TW-1:0]  w_addr;
    logic [PW-1:0]  pix;
    logic           pad_zero, tap_first, tap_last, layer_last;

    logic [ROM_LAT-1:0] al_vld_q, al_first_q, al_last_q;
    logic [PW-1:0]      al_pix_q [ROM_LAT];
    logic [MAC_LAT-1:0] sm_vld_q;
    logic [PW-1:0]      sm_pix_q [MAC_LAT];
    logic               mac_en;

    assign run   = (state_q == RUN);
    assign issue = run && !bus.hold;
    assign clear = bus.start && ((state_q == IDLE) || (state_q == DONE));

    fire_tap_counter #(
        .W_IN(W_IN), .H_IN(H_IN), .CHIN(CHIN), .KERNEL_DIM(KERNEL_DIM), .PAD(PAD),
        .IA(IA), .TW(TW), .PW(PW)
    ) u_taps (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (clear),
        .advance_i   (issue),
        .ifm_addr_o  (ifm_addr),
        .w_addr_o    (w_addr),
        .pix_o       (pix),
        .pad_zero_o  (pad_zero),
        .first_o     (tap_first),
        .last_o      (tap_last),
        .layer_last_o(layer_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= (state_q == DRAIN) ? drain_q + 1'b1 : '0;
        end
    end

    always_comb begin
        state_d     = state_q;
        busy_d      = 1'b0;
        layer_end_d = 1'b0;
        case (state_q)
            IDLE:  if (bus.start) state_d = RUN;
            RUN: begin
                busy_d = 1'b1;
                if (issue && layer_last) state_d = DRAIN;
            end
            DRAIN: begin
                busy_d = 1'b1;
                if (drain_q == DW'(DRAIN_LEN - 1)) state_d = DONE;
            end
            DONE: begin
                layer_end_d = 1'b1;
                if (bus.start) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    // p0: issue -> aligned with registered kernel; p1: aligned last tap -> accumulator valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            al_vld_q   <= '0;
            al_first_q <= '0;
            al_last_q  <= '0;
            sm_vld_q   <= '0;
            for (int i = 0; i < ROM_LAT; i++) al_pix_q[i] <= '0;
            for (int i = 0; i < MAC_LAT; i++) sm_pix_q[i] <= '0;
        end else begin
            al_vld_q[0]   <= issue;
            al_first_q[0] <= tap_first;
            al_last_q[0]  <= tap_last;
            al_pix_q[0]   <= pix;
            for (int i = 1; i < ROM_LAT; i++) begin
                al_vld_q[i]   <= al_vld_q[i-1];
                al_first_q[i] <= al_first_q[i-1];
                al_last_q[i]  <= al_last_q[i-1];
                al_pix_q[i]   <= al_pix_q[i-1];
            end
            sm_vld_q[0] <= mac_en && al_last_q[ROM_LAT-1];
            sm_pix_q[0] <= al_pix_q[ROM_LAT-1];
            for (int i = 1; i < MAC_LAT; i++) begin
                sm_vld_q[i] <= sm_vld_q[i-1];
                sm_pix_q[i] <= sm_pix_q[i-1];
            end
        end
    end

    assign mac_en         = al_vld_q[ROM_LAT-1];
    assign bus.mac_en     = mac_en;
    assign bus.mac_clr    = mac_en && al_first_q[ROM_LAT-1];
    assign bus.ofm_sample = sm_vld_q[MAC_LAT-1];
    assign bus.ofm_pix    = sm_vld_q[MAC_LAT-1] ? sm_pix_q[MAC_LAT-1] : '0;
    assign bus.ifm_addr   = run ? ifm_addr : '0;
    assign bus.w_addr     = run ? w_addr : '0;
    assign bus.pad_zero   = run && pad_zero;
    assign bus.busy       = busy_d;
    assign bus.layer_end  = layer_end_d;

endmodule

// File: tb/tb_fire_expand_sequencer.sv
// Directed bench for fire_expand_sequencer on a 4x4x2 layer with a 3x3 kernel.
module tb_fire_expand_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fire_expand_sequencer_if #(.IFM_AW(5), .W_AW(5), .PIX_AW(4)) bus ();

    fire_expand_sequencer #(
        .W_IN(4), .H_IN(4), .CHIN(2), .KERNEL_DIM(3), .PAD(1), .ROM_LAT(1), .MAC_LAT(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int cyc; int w; int ifm; bit pad; bit en; bit clr; bit smp; int pix; bit busy; bit lend;
    } vec_t;

    vec_t vecs[$];
    int checks = 0;
    int errors = 0;

    function automatic vec_t mk(int cyc, int w, int ifm, bit pad, bit en, bit clr, bit smp,
                                int pix, bit busy, bit lend);
        vec_t v;
        v.cyc = cyc; v.w = w; v.ifm = ifm; v.pad = pad; v.en = en; v.clr = clr;
        v.smp = smp; v.pix = pix; v.busy = busy; v.lend = lend;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_vec(input vec_t v);
        chk($sformatf("c%0d w_addr", v.cyc),     32'(bus.w_addr),     32'(v.w));
        chk($sformatf("c%0d ifm_addr", v.cyc),   32'(bus.ifm_addr),   32'(v.ifm));
        chk($sformatf("c%0d pad_zero", v.cyc),   32'(bus.pad_zero),   32'(v.pad));
        chk($sformatf("c%0d mac_en", v.cyc),     32'(bus.mac_en),     32'(v.en));
        chk($sformatf("c%0d mac_clr", v.cyc),    32'(bus.mac_clr),    32'(v.clr));
        chk($sformatf("c%0d ofm_sample", v.cyc), 32'(bus.ofm_sample), 32'(v.smp));
        chk($sformatf("c%0d ofm_pix", v.cyc),    32'(bus.ofm_pix),    32'(v.pix));
        chk($sformatf("c%0d busy", v.cyc),       32'(bus.busy),       32'(v.busy));
        chk($sformatf("c%0d layer_end", v.cyc),  32'(bus.layer_end),  32'(v.lend));
    endtask

    task automatic check_idle(input string tag);
        check_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        chk({tag, " idle state"}, 32'(bus.busy | bus.layer_end), 32'd0);
    endtask

    // Runs one layer for 300 cycles after the start pulse; hold_len stall cycles begin at hold_from.
    task automatic run_layer(input int hold_from, input int hold_len, input int start_busy_at,
                             input int drain_hold_from, input bit use_table);
        int nsamp, lend_cyc, pad5, pad15, exp_c;
        nsamp = 0; lend_cyc = -1; pad5 = 0; pad15 = 0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int c = 1; c <= 300; c++) begin
            if (use_table)
                foreach (vecs[i]) if (vecs[i].cyc == c) check_vec(vecs[i]);
            if (c == 1) begin
                chk("c1 layer_end cleared", 32'(bus.layer_end), 32'd0);
                chk("c1 busy", 32'(bus.busy), 32'd1);
            end
            if (bus.ofm_sample) begin
                exp_c = 21 + 18 * nsamp + ((nsamp >= 3) ? hold_len : 0);
                chk($sformatf("sample %0d pix", nsamp), 32'(bus.ofm_pix), 32'(nsamp));
                chk($sformatf("sample %0d cycle", nsamp), 32'(c), 32'(exp_c));
                nsamp++;
            end
            if (bus.layer_end && lend_cyc < 0) lend_cyc = c;
            if (hold_len == 0) begin
                if (c <= 288) chk($sformatf("c%0d w_addr seq", c), 32'(bus.w_addr), 32'((c - 1) % 18));
                if (c >= 2 && c <= 289) chk($sformatf("c%0d mac_en run", c), 32'(bus.mac_en), 32'd1);
                if (c >= 91 && c <= 108) pad5 += int'(bus.pad_zero);
                if (c >= 271 && c <= 288) pad15 += int'(bus.pad_zero);
            end else begin
                if (c >= hold_from && c < hold_from + hold_len) begin
                    chk($sformatf("c%0d held w_addr", c), 32'(bus.w_addr), 32'd5);
                    chk($sformatf("c%0d held pad_zero", c), 32'(bus.pad_zero), 32'd1);
                end
                if (c > hold_from && c <= hold_from + hold_len)
                    chk($sformatf("c%0d bubble mac_en", c), 32'(bus.mac_en), 32'd0);
                if (c == hold_from + hold_len + 1)
                    chk("resume mac_en", 32'(bus.mac_en), 32'd1);
            end
            bus.hold  = ((c >= hold_from) && (c < hold_from + hold_len)) ||
                        ((c >= drain_hold_from) && (c < drain_hold_from + 4));
            bus.start = (c == start_busy_at);
            step();
        end
        bus.hold = 1'b0;
        chk("sample count", 32'(nsamp), 32'd16);
        chk("layer_end cycle", 32'(lend_cyc), 32'(292 + hold_len));
        chk("layer_end sticky", 32'(bus.layer_end), 32'd1);
        if (hold_len == 0) begin
            chk("pix5 pad taps", 32'(pad5), 32'd0);
            chk("pix15 pad taps", 32'(pad15), 32'd10);
        end
    endtask

    initial begin
        int nsmp, nbusy;
        vecs.push_back(mk(  1,  0,  0, 1, 0, 0, 0,  0, 1, 0));
        vecs.push_back(mk(  2,  1,  0, 1, 1, 1, 0,  0, 1, 0));
        vecs.push_back(mk(  3,  2,  0, 1, 1, 0, 0,  0, 1, 0));
        vecs.push_back(mk(  9,  8,  0, 0, 1, 0, 0,  0, 1, 0));
        vecs.push_back(mk( 10,  9,  1, 0, 1, 0, 0,  0, 1, 0));
        vecs.push_back(mk( 11, 10,  2, 0, 1, 0, 0,  0, 1, 0));
        vecs.push_back(mk( 18, 17, 11, 0, 1, 0, 0,  0, 1, 0));
        vecs.push_back(mk( 19,  0,  0, 1, 1, 0, 0,  0, 1, 0));
        vecs.push_back(mk( 20,  1,  0, 1, 1, 1, 0,  0, 1, 0));
        vecs.push_back(mk( 21,  2,  0, 1, 1, 0, 1,  0, 1, 0));
        vecs.push_back(mk( 91,  0,  0, 0, 1, 0, 0,  0, 1, 0));
        vecs.push_back(mk(108, 17, 21, 0, 1, 0, 0,  0, 1, 0));
        vecs.push_back(mk(279,  8, 30, 0, 1, 0, 0,  0, 1, 0));
        vecs.push_back(mk(288, 17,  0, 1, 1, 0, 0,  0, 1, 0));
        vecs.push_back(mk(289,  0,  0, 0, 1, 0, 0,  0, 1, 0));
        vecs.push_back(mk(290,  0,  0, 0, 0, 0, 0,  0, 1, 0));
        vecs.push_back(mk(291,  0,  0, 0, 0, 0, 1, 15, 1, 0));
        vecs.push_back(mk(292,  0,  0, 0, 0, 0, 0,  0, 0, 1));

        rst = 1'b1;
        bus.start = 1'b0;
        bus.hold  = 1'b0;
        repeat (3) step();
        check_idle("in reset");
        rst = 1'b0;
        step();
        check_idle("after reset");

        // Full layer: extra start while busy, hold throughout drain and into DONE.
        run_layer(-100, 0, 100, 289, 1'b1);
        // Restart from DONE with a 4-cycle stall at tap 5 of pixel 3.
        run_layer(60, 4, -1, -100, 1'b0);

        // Reset mid-layer aborts without any later sample.
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (49) step();
        chk("mid-layer busy before reset", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        repeat (3) step();
        check_idle("mid-layer reset");
        rst = 1'b0;
        nsmp = 0; nbusy = 0;
        for (int c = 0; c < 30; c++) begin
            nsmp  += int'(bus.ofm_sample);
            nbusy += int'(bus.busy | bus.mac_en | bus.layer_end);
            step();
        end
        chk("samples after abort", 32'(nsmp), 32'd0);
        chk("activity after abort", 32'(nbusy), 32'd0);

        // Fresh start from IDLE after the abort begins at pixel 0 tap 0.
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check_vec(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
